best_weight_tracker: RTL and testbench
======================================

# best_weight_tracker

Keeps the lowest-error weight set seen during training and serves it as `BEST_WEIGHT` to the memory mux that selects between training output and best weights. Weights streamed by the training datapath are written into a shadow bank each epoch. At epoch end the reported error is compared against the best so far, and the shadow bank is promoted by a ping-pong pointer swap, so no copy is made. Sits directly upstream of the weight mux's `BEST_WEIGHT` input.

## Interface
- `BIT_WIDTH`, 32, weight magnitude width; also the error width
- `EXTRA_BIT`, 2, extra guard bits per weight; the weight word is `BIT_WIDTH+EXTRA_BIT`
- `NUM_WEIGHTS`, 16, weights per epoch set
- `ADDR_WIDTH`, 4, address width, ≥ clog2(NUM_WEIGHTS)
- `PATIENCE`, 8, non-improving epochs before early stop (only with the macro)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `epoch_start`  in  1  pulse; opens a collection epoch
- `weight_valid`  in  1  weight beat strobe
- `weight_addr`  in  ADDR_WIDTH  weight index
- `weight_in`  in  BIT_WIDTH+EXTRA_BIT  weight value
- `epoch_done`  in  1  pulse; closes the epoch, `epoch_error` valid
- `epoch_error`  in  BIT_WIDTH  unsigned epoch error
- `training_finish`  in  1  level; freezes tracking
- `rd_addr`  in  ADDR_WIDTH  best-weight read index
- `BEST_WEIGHT`  out  BIT_WIDTH+EXTRA_BIT  registered best weight at `rd_addr`
- `best_error`  out  BIT_WIDTH  error of the stored set
- `best_valid`  out  1  a best set exists
- `best_updated`  out  1  one-cycle pulse on promotion
- `epoch_dropped`  out  1  one-cycle pulse: epoch discarded as incomplete
- `busy`  out  1  high in COLLECT or COMPARE

## Operation
- FSM states: IDLE, COLLECT, COMPARE.
  - IDLE → COLLECT on `epoch_start` when `training_finish` is 0. The beat counter clears.
  - COLLECT: each `weight_valid` writes `weight_in` to `shadow[weight_addr]` (bank `~best_bank`) and increments the beat counter, saturating at NUM_WEIGHTS.
  - COLLECT → COMPARE on `epoch_done`, latching `epoch_error`. A beat in the same cycle as `epoch_done` is included.
  - COMPARE → IDLE always, after one cycle.
- Decision in COMPARE:
  - If beat count ≠ NUM_WEIGHTS: pulse `epoch_dropped`; no promotion.
  - Otherwise, if `!best_valid` or latched error < `best_error` (strict, unsigned): flip `best_bank`, load `best_error`, set `best_valid`, pulse `best_updated`.
  - An equal error does not promote.
- Duplicate addresses within an epoch overwrite and still count as beats.
- Inputs are ignored when not applicable:
  - `weight_valid` and `epoch_done` outside COLLECT.
  - `epoch_start` outside IDLE.
- `training_finish` high forces IDLE from any state next cycle and discards an in-flight epoch with no drop pulse. Reads remain available.
- Read: `BEST_WEIGHT` ← `best_valid ? bank[best_bank][rd_addr] : 0`. An out-of-range `rd_addr` returns 0.
- Reset values (all outputs and state):
  - All outputs 0, `best_error` all ones, `best_valid` 0, `best_bank` 0, state IDLE.
  - RAM contents are not reset; `best_valid` guards them.
  - Reset mid-epoch discards everything.

## Timing
- Write: beat sampled at the rising edge and visible in the shadow bank the next cycle.
- The `epoch_done` edge moves the FSM to COMPARE. At the end of COMPARE, `best_bank`, `best_error`, `best_valid` and the pulses update together.
- `BEST_WEIGHT` latency is 1 cycle from `rd_addr`. A read issued in the COMPARE cycle returns the old bank; the new bank is visible from the following read.
- Minimum epoch: `epoch_start` → 1 beat … → `epoch_done` → COMPARE → IDLE. A new `epoch_start` is accepted the cycle after COMPARE.

## Configuration
- Macro `BEST_TRACK_PATIENCE_EN`.
- Defined:
  - Adds output `early_stop` (1 bit, reset 0) and a stall counter.
  - The counter increments on each complete, non-promoting epoch, saturating at PATIENCE.
  - The counter clears on promotion or reset.
  - `early_stop` is a sticky level that asserts in the cycle after the counter reaches PATIENCE; only reset clears it.
  - Dropped epochs do not count.
- Undefined: no port, no counter, behaviour otherwise identical.

## Structure
- Shared package/header `best_weight_pkg`:
  - FSM state encoding (IDLE=0, COLLECT=1, COMPARE=2)
  - word width `BIT_WIDTH+EXTRA_BIT`
  - reset error constant (all ones)
- Sub-module `weight_bank_ram`:
  - 2×NUM_WEIGHTS dual-port RAM
  - one synchronous write port (bank select + address)
  - one synchronous read port
  - registered output feeds `BEST_WEIGHT`

## Test plan
- Reset, then read addr 3 → `BEST_WEIGHT`=0, `best_valid`=0, `best_error`=0xFFFFFFFF.
- Full epoch with weights w[i]=i+1 and error 100 → `best_updated` pulse; read addr 5 gives 6 one cycle later; `best_error`=100.
- Second epoch, w[i]=0x20+i, error 100 (equal) → no promotion; read addr 5 still 6. Third epoch, error 50 → addr 5 reads 0x25.
- Epoch with only 15 beats, error 1 → `epoch_dropped` pulse, `best_error` unchanged.
- `training_finish` mid-COLLECT after 8 beats → IDLE, no pulses; later `epoch_start` ignored while `training_finish` stays high.
- With `BEST_TRACK_PATIENCE_EN`, PATIENCE=2, best=10: two complete epochs with error 20 → `early_stop`=1 the cycle after the second COMPARE.

Source files
------------

// File: rtl/best_weight_pkg.sv
// best_weight_pkg: shared FSM encoding, default widths and reset constants
// for the best-weight tracker slice.
package best_weight_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_COMPARE = 2'd2
   } tracker_state_t;

   localparam int unsigned DEF_BIT_WIDTH  = 32;
   localparam int unsigned DEF_EXTRA_BIT  = 2;
   localparam int unsigned DEF_WORD_WIDTH = DEF_BIT_WIDTH + DEF_EXTRA_BIT;

   // Error value held before any set has been stored
   localparam logic [DEF_BIT_WIDTH-1:0] RESET_ERROR = '1;

   function automatic int unsigned word_width(input int unsigned bit_width,
                                              input int unsigned extra_bit);
      return bit_width + extra_bit;
   endfunction

endpackage

// File: rtl/weight_bank_ram.sv
// weight_bank_ram: two banks of NUM_WEIGHTS words. One synchronous write
// port (bank + address), one synchronous read port with a registered output
// that can be forced to zero by the caller.
module weight_bank_ram #(
   parameter int unsigned WORD_WIDTH  = 34,
   parameter int unsigned NUM_WEIGHTS = 16,
   parameter int unsigned ADDR_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic                  wr_bank,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WORD_WIDTH-1:0] wr_data,
   input  logic                  rd_bank,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  rd_zero,
   output logic [WORD_WIDTH-1:0] rd_data
);

   localparam int unsigned DEPTH = 2 * NUM_WEIGHTS;
   localparam int unsigned IDX_W = ADDR_WIDTH + 1;

   logic [WORD_WIDTH-1:0] mem [DEPTH];

   // Bank 1 lives directly above bank 0
   function automatic logic [IDX_W-1:0] row(input logic bank,
                                            input logic [ADDR_WIDTH-1:0] addr);
      return (bank ? IDX_W'(NUM_WEIGHTS) : '0) + {1'b0, addr};
   endfunction

   // Write port: contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[row(wr_bank, wr_addr)] <= wr_data;
      end
   end

   // Registered read port feeding BEST_WEIGHT
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_zero) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[row(rd_bank, rd_addr)];
      end
   end

endmodule

// File: rtl/best_weight_tracker.sv
// best_weight_tracker: collects one weight set per epoch into the shadow
// bank and promotes it by flipping best_bank when its error is strictly
// lower than the stored best. Optional macro BEST_TRACK_PATIENCE_EN adds an
// early_stop output driven by a non-improving-epoch counter.
module best_weight_tracker
   import best_weight_pkg::*;
#(
   parameter int unsigned BIT_WIDTH   = DEF_BIT_WIDTH,
   parameter int unsigned EXTRA_BIT   = DEF_EXTRA_BIT,
   parameter int unsigned NUM_WEIGHTS = 16,
   parameter int unsigned ADDR_WIDTH  = 4,
   parameter int unsigned PATIENCE    = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           epoch_start,
   input  logic                           weight_valid,
   input  logic [ADDR_WIDTH-1:0]          weight_addr,
   input  logic [BIT_WIDTH+EXTRA_BIT-1:0] weight_in,
   input  logic                           epoch_done,
   input  logic [BIT_WIDTH-1:0]           epoch_error,
   input  logic                           training_finish,
   input  logic [ADDR_WIDTH-1:0]          rd_addr,
   output logic [BIT_WIDTH+EXTRA_BIT-1:0] BEST_WEIGHT,
   output logic [BIT_WIDTH-1:0]           best_error,
   output logic                           best_valid,
   output logic                           best_updated,
   output logic                           epoch_dropped,
   output logic                           busy
`ifdef BEST_TRACK_PATIENCE_EN
   ,output logic                          early_stop
`endif
);

   localparam int unsigned WORD_W = word_width(BIT_WIDTH, EXTRA_BIT);
   localparam int unsigned CNT_W  = $clog2(NUM_WEIGHTS + 1);
   localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(NUM_WEIGHTS);
   localparam logic [ADDR_WIDTH:0]   NUM_A    = (ADDR_WIDTH+1)'(NUM_WEIGHTS);

   tracker_state_t       state;
   logic [CNT_W-1:0]     beat_cnt;
   logic [BIT_WIDTH-1:0] err_latched;
   logic                 best_bank;

   logic wr_en;
   logic rd_zero;

   // Shadow-bank writes only while collecting and not being frozen
   always_comb begin
      wr_en   = (state == ST_COLLECT) && weight_valid && !training_finish &&
                ({1'b0, weight_addr} < NUM_A);
      rd_zero = !best_valid || ({1'b0, rd_addr} >= NUM_A);
   end

   weight_bank_ram #(
      .WORD_WIDTH  (WORD_W),
      .NUM_WEIGHTS (NUM_WEIGHTS),
      .ADDR_WIDTH  (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_bank (~best_bank),
      .wr_addr (weight_addr),
      .wr_data (weight_in),
      .rd_bank (best_bank),
      .rd_addr (rd_addr),
      .rd_zero (rd_zero),
      .rd_data (BEST_WEIGHT)
   );

`ifdef BEST_TRACK_PATIENCE_EN
   localparam int unsigned STALL_W = $clog2(PATIENCE + 1);
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(PATIENCE);
   logic [STALL_W-1:0] stall_cnt;
`endif

   // Epoch FSM with registered status outputs and promotion decision
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         beat_cnt      <= '0;
         err_latched   <= '0;
         best_bank     <= 1'b0;
         best_error    <= '1;
         best_valid    <= 1'b0;
         best_updated  <= 1'b0;
         epoch_dropped <= 1'b0;
         busy          <= 1'b0;
`ifdef BEST_TRACK_PATIENCE_EN
         stall_cnt     <= '0;
         early_stop    <= 1'b0;
`endif
      end else begin
         best_updated  <= 1'b0;
         epoch_dropped <= 1'b0;
`ifdef BEST_TRACK_PATIENCE_EN
         if (stall_cnt == STALL_MAX) begin
            early_stop <= 1'b1;
         end
`endif
         if (training_finish) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (epoch_start) begin
                     state    <= ST_COLLECT;
                     beat_cnt <= '0;
                     busy     <= 1'b1;
                  end
               end
               ST_COLLECT: begin
                  if (weight_valid && (beat_cnt != FULL_CNT)) begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
                  if (epoch_done) begin
                     err_latched <= epoch_error;
                     state       <= ST_COMPARE;
                  end
               end
               ST_COMPARE: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  if (beat_cnt != FULL_CNT) begin
                     epoch_dropped <= 1'b1;
                  end else if (!best_valid || (err_latched < best_error)) begin
                     best_bank    <= ~best_bank;
                     best_error   <= err_latched;
                     best_valid   <= 1'b1;
                     best_updated <= 1'b1;
`ifdef BEST_TRACK_PATIENCE_EN
                     stall_cnt    <= '0;
`endif
                  end else begin
`ifdef BEST_TRACK_PATIENCE_EN
                     if (stall_cnt != STALL_MAX) begin
                        stall_cnt <= stall_cnt + 1'b1;
                     end
`endif
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_best_weight_tracker.sv
// Directed self-checking bench for best_weight_tracker (default build).
module tb_best_weight_tracker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        epoch_start;
   logic        weight_valid;
   logic [3:0]  weight_addr;
   logic [33:0] weight_in;
   logic        epoch_done;
   logic [31:0] epoch_error;
   logic        training_finish;
   logic [3:0]  rd_addr;
   logic [33:0] BEST_WEIGHT;
   logic [31:0] best_error;
   logic        best_valid;
   logic        best_updated;
   logic        epoch_dropped;
   logic        busy;
`ifdef BEST_TRACK_PATIENCE_EN
   logic        early_stop;
`endif

   int checks   = 0;
   int failures = 0;

   best_weight_tracker #(
      .BIT_WIDTH   (32),
      .EXTRA_BIT   (2),
      .NUM_WEIGHTS (16),
      .ADDR_WIDTH  (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .epoch_start     (epoch_start),
      .weight_valid    (weight_valid),
      .weight_addr     (weight_addr),
      .weight_in       (weight_in),
      .epoch_done      (epoch_done),
      .epoch_error     (epoch_error),
      .training_finish (training_finish),
      .rd_addr         (rd_addr),
      .BEST_WEIGHT     (BEST_WEIGHT),
      .best_error      (best_error),
      .best_valid      (best_valid),
      .best_updated    (best_updated),
      .epoch_dropped   (epoch_dropped),
      .busy            (busy)
`ifdef BEST_TRACK_PATIENCE_EN
      ,.early_stop     (early_stop)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a whole epoch; returns the pulses seen the cycle after COMPARE
   task automatic run_epoch(input int nbeats, input logic [33:0] base,
                            input logic [31:0] err,
                            output logic upd, output logic drop);
      epoch_start = 1'b1;
      tick();
      epoch_start = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         weight_valid = 1'b1;
         weight_addr  = 4'(i);
         weight_in    = base + 34'(i);
         if (i == nbeats - 1) begin
            epoch_done  = 1'b1;
            epoch_error = err;
         end
         tick();
      end
      weight_valid = 1'b0;
      epoch_done   = 1'b0;
      tick();
      upd  = best_updated;
      drop = epoch_dropped;
   endtask

   task automatic read_check(input string name, input logic [3:0] a,
                             input logic [33:0] exp);
      rd_addr = a;
      tick();
      checks++;
      if (BEST_WEIGHT !== exp) begin
         failures++;
         $display("FAIL %s: BEST_WEIGHT got %h expected %h", name, BEST_WEIGHT, exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; epoch_start = 1'b0; weight_valid = 1'b0; weight_addr = '0;
      weight_in = '0; epoch_done = 1'b0; epoch_error = '0;
      training_finish = 1'b0; rd_addr = 4'd3;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (BEST_WEIGHT !== 34'h0) begin
         failures++; $display("FAIL reset_weight: got %h expected 0", BEST_WEIGHT);
      end
      checks++;
      if (best_valid !== 1'b0) begin
         failures++; $display("FAIL reset_valid: got %b expected 0", best_valid);
      end
      checks++;
      if (best_error !== 32'hFFFF_FFFF) begin
         failures++; $display("FAIL reset_error: got %h expected ffffffff", best_error);
      end
      checks++;
      if ({busy, best_updated, epoch_dropped} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 000", {busy, best_updated, epoch_dropped});
      end
   endtask

   task automatic test_first_epoch();
      logic upd, drop;
      run_epoch(16, 34'h1, 32'd100, upd, drop);
      checks++;
      if ({upd, drop} !== 2'b10) begin
         failures++; $display("FAIL first_pulses: got %b expected 10", {upd, drop});
      end
      checks++;
      if (best_error !== 32'd100 || best_valid !== 1'b1) begin
         failures++;
         $display("FAIL first_error: got %0d/%b expected 100/1", best_error, best_valid);
      end
      read_check("first_addr5", 4'd5, 34'h6);
      checks++;
      if (best_updated !== 1'b0) begin
         failures++; $display("FAIL first_pulse_width: got %b expected 0", best_updated);
      end
      read_check("first_addr15", 4'd15, 34'h10);
   endtask

   task automatic test_equal_then_better();
      logic upd, drop;
      run_epoch(16, 34'h20, 32'd100, upd, drop);
      checks++;
      if ({upd, drop} !== 2'b00) begin
         failures++; $display("FAIL equal_pulses: got %b expected 00", {upd, drop});
      end
      read_check("equal_addr5", 4'd5, 34'h6);
      run_epoch(16, 34'h20, 32'd50, upd, drop);
      checks++;
      if ({upd, drop} !== 2'b10) begin
         failures++; $display("FAIL better_pulses: got %b expected 10", {upd, drop});
      end
      read_check("better_addr5", 4'd5, 34'h25);
      checks++;
      if (best_error !== 32'd50) begin
         failures++; $display("FAIL better_error: got %0d expected 50", best_error);
      end
   endtask

   task automatic test_drop();
      logic upd, drop;
      run_epoch(15, 34'h40, 32'd1, upd, drop);
      checks++;
      if ({upd, drop} !== 2'b01) begin
         failures++; $display("FAIL drop_pulses: got %b expected 01", {upd, drop});
      end
      checks++;
      if (best_error !== 32'd50) begin
         failures++; $display("FAIL drop_error: got %0d expected 50", best_error);
      end
      read_check("drop_addr5", 4'd5, 34'h25);
   endtask

   task automatic test_training_finish();
      int pulses = 0;
      epoch_start = 1'b1;
      tick();
      epoch_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         weight_valid = 1'b1; weight_addr = 4'(i); weight_in = 34'h50 + 34'(i);
         tick();
      end
      weight_valid = 1'b0;
      training_finish = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL finish_idle: busy got %b expected 0", busy);
      end
      epoch_start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pulses += int'(best_updated) + int'(epoch_dropped) + int'(busy);
         tick();
      end
      epoch_start = 1'b0;
      checks++;
      if (pulses != 0) begin
         failures++; $display("FAIL finish_quiet: activity got %0d expected 0", pulses);
      end
      read_check("finish_read", 4'd5, 34'h25);
      training_finish = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || best_error !== 32'd50) begin
         failures++;
         $display("FAIL finish_after: busy/err got %b/%0d expected 0/50", busy, best_error);
      end
   endtask

   // Read during COMPARE sees old bank; next epoch_start right after COMPARE
   task automatic test_back_to_back();
      epoch_start = 1'b1;
      tick();
      epoch_start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         weight_valid = 1'b1; weight_addr = 4'(i); weight_in = 34'h60 + 34'(i);
         if (i == 15) begin
            epoch_done = 1'b1; epoch_error = 32'd10;
         end
         tick();
      end
      weight_valid = 1'b0; epoch_done = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL b2b_compare_busy: got %b expected 1", busy);
      end
      read_check("b2b_old_bank", 4'd5, 34'h25);
      checks++;
      if (best_updated !== 1'b1) begin
         failures++; $display("FAIL b2b_update: got %b expected 1", best_updated);
      end
      epoch_start = 1'b1;
      tick();
      epoch_start = 1'b0;
      checks++;
      if (BEST_WEIGHT !== 34'h65 || busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_new_bank: weight/busy got %h/%b expected 65/1", BEST_WEIGHT, busy);
      end
      for (int i = 0; i < 16; i++) begin
         weight_valid = 1'b1; weight_addr = 4'(i); weight_in = 34'h70 + 34'(i);
         if (i == 15) begin
            epoch_done = 1'b1; epoch_error = 32'd5;
         end
         tick();
      end
      weight_valid = 1'b0; epoch_done = 1'b0;
      tick();
      checks++;
      if (best_updated !== 1'b1 || best_error !== 32'd5) begin
         failures++;
         $display("FAIL b2b_second: upd/err got %b/%0d expected 1/5", best_updated, best_error);
      end
      read_check("b2b_second_addr0", 4'd0, 34'h70);
   endtask

   // Duplicate addresses still count; unwritten slots keep stale bank data
   task automatic test_duplicate();
      epoch_start = 1'b1;
      tick();
      epoch_start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         weight_valid = 1'b1;
         weight_addr  = (i < 14) ? 4'(i) : 4'd3;
         weight_in    = 34'h80 + 34'(i);
         if (i == 15) begin
            epoch_done = 1'b1; epoch_error = 32'd1;
         end
         tick();
      end
      weight_valid = 1'b0; epoch_done = 1'b0;
      tick();
      checks++;
      if ({best_updated, epoch_dropped} !== 2'b10) begin
         failures++;
         $display("FAIL dup_pulses: got %b expected 10", {best_updated, epoch_dropped});
      end
      read_check("dup_addr3", 4'd3, 34'h8F);
      read_check("dup_addr15", 4'd15, 34'h6F);
   endtask

   initial begin
      test_reset();
      test_first_epoch();
      test_equal_then_better();
      test_drop();
      test_training_finish();
      test_back_to_back();
      test_duplicate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
